// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and polarity helper for the scan driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

   localparam int unsigned SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
   localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
   localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
   localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
   localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] seg,
                                                     input logic             active_low);
      return active_low ? ~seg : seg;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Producer-side load bus and board-side display pins of the scan driver.
interface seg7_scan_driver_if #(
   parameter int unsigned NUM_DIGITS = 8
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    blank_lz;
   logic                    load;
   logic [6:0]              cathodes;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   anodes;
   logic                    frame_done;

   modport master (
      output digits_in, dp_in, digit_en, blank_lz, load,
      input  cathodes, dp, anodes, frame_done
   );

   modport slave (
      input  digits_in, dp_in, digit_en, blank_lz, load,
      output cathodes, dp, anodes, frame_done
   );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern, active-high.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] seg
);
   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with a double-buffered digit bank
// that swaps only at frame boundaries.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 8,
   parameter int unsigned SLOT_CYCLES = 10000,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input logic               clk_5MHz,
   input logic               reset,
   seg7_scan_driver_if.slave bus
);
   localparam int unsigned   IW        = $clog2(NUM_DIGITS);
   localparam int unsigned   CW        = $clog2(SLOT_CYCLES);
   localparam int unsigned   DW        = 4 * NUM_DIGITS;
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx, idx_next, above_idx, first_idx;
   logic                  tick, boundary, above_found, nb_any;
   logic [DW-1:0]         sh_dig, act_dig, ld_dig, nb_dig;
   logic [NUM_DIGITS-1:0] sh_dp, act_dp, ld_dp, nb_dp;
   logic [NUM_DIGITS-1:0] sh_en, act_en, ld_en, nb_en;
   logic                  sh_blz, act_blz, ld_blz, nb_blz;
   logic [3:0]            nb_nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] blanked;
   logic [3:0]            cur_nib;
   logic [SEG_W-1:0]      dec_seg, seg_c;
   logic [NUM_DIGITS-1:0] an_c;
   logic                  dp_c;
   logic [NUM_DIGITS-1:0] an_q;
   logic [SEG_W-1:0]      cath_q;
   logic                  dp_q, fd_q;

   // Lowest enabled index strictly above cur; MSB flags that one exists.
   function automatic logic [IW:0] next_above(input logic [NUM_DIGITS-1:0] en,
                                              input logic [IW-1:0]         cur);
      logic [IW:0] r;
      r = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--)
         if (en[i] && (IW'(i) > cur)) r = {1'b1, IW'(i)};
      return r;
   endfunction

   function automatic logic [IW-1:0] lowest_en(input logic [NUM_DIGITS-1:0] en);
      logic [IW-1:0] r;
      r = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--)
         if (en[i]) r = IW'(i);
      return r;
   endfunction

   // Boundary detection, bank selection (with load bypass) and index search.
   always_comb begin
      tick                     = (cnt == '0);
      {above_found, above_idx} = next_above(act_en, idx);
      boundary                 = tick && (!(|act_en) || !above_found);

      if (bus.load) {ld_dig, ld_dp, ld_en, ld_blz} = {bus.digits_in, bus.dp_in, bus.digit_en, bus.blank_lz};
      else          {ld_dig, ld_dp, ld_en, ld_blz} = {sh_dig, sh_dp, sh_en, sh_blz};

      if (boundary) {nb_dig, nb_dp, nb_en, nb_blz} = {ld_dig, ld_dp, ld_en, ld_blz};
      else          {nb_dig, nb_dp, nb_en, nb_blz} = {act_dig, act_dp, act_en, act_blz};

      nb_any    = |nb_en;
      first_idx = lowest_en(nb_en);
      idx_next  = idx;
      if (tick) begin
         if (boundary) begin
            if (nb_any) idx_next = first_idx;
         end else begin
            idx_next = above_idx;
         end
      end

      for (int i = 0; i < int'(NUM_DIGITS); i++)
         nb_nib[i] = nb_en[i] ? nb_dig[4*i +: 4] : 4'h0;

      // Blank runs of zeros from the top down; digit 0 always shows.
      blanked = '0;
      begin
         logic lz;
         lz = nb_blz;
         for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            if (nb_nib[i] != 4'h0) lz = 1'b0;
            blanked[i] = lz;
         end
      end
      cur_nib = nb_nib[idx_next];
   end

   seg7_hex_decode u_dec (
      .nibble (cur_nib),
      .seg    (dec_seg)
   );

   // Active-high slot image for the digit about to be shown.
   always_comb begin
      an_c  = '0;
      seg_c = SEG_BLANK;
      dp_c  = 1'b0;
      if (nb_any) begin
         an_c[idx_next] = 1'b1;
         dp_c           = nb_dp[idx_next];
         if (!blanked[idx_next]) seg_c = dec_seg;
      end
   end

   always_ff @(posedge clk_5MHz) begin
      if (reset) begin
         cnt     <= SLOT_LAST;
         idx     <= '0;
         sh_dig  <= '0;
         sh_dp   <= '0;
         sh_en   <= '0;
         sh_blz  <= 1'b0;
         act_dig <= '0;
         act_dp  <= '0;
         act_en  <= '0;
         act_blz <= 1'b0;
         an_q    <= {NUM_DIGITS{ACTIVE_LOW}};
         cath_q  <= seg_polarity(SEG_BLANK, ACTIVE_LOW);
         dp_q    <= ACTIVE_LOW;
         fd_q    <= 1'b0;
      end else begin
         cnt <= tick ? SLOT_LAST : cnt - CW'(1);
         if (bus.load) {sh_dig, sh_dp, sh_en, sh_blz} <= {bus.digits_in, bus.dp_in, bus.digit_en, bus.blank_lz};
         if (boundary) {act_dig, act_dp, act_en, act_blz} <= {ld_dig, ld_dp, ld_en, ld_blz};
         if (tick) begin
            idx    <= idx_next;
            an_q   <= an_c ^ {NUM_DIGITS{ACTIVE_LOW}};
            cath_q <= seg_polarity(seg_c, ACTIVE_LOW);
            dp_q   <= dp_c ^ ACTIVE_LOW;
         end
         fd_q <= boundary;
      end
   end

   assign bus.anodes     = an_q;
   assign bus.cathodes   = cath_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle slots, active-low pins.
module tb_seg7_scan_driver;
   localparam int unsigned ND = 4;

   logic clk = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;

   seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_driver #(
      .NUM_DIGITS  (ND),
      .SLOT_CYCLES (4),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk_5MHz (clk),
      .reset    (reset),
      .bus      (bus)
   );

   always #10 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] an,
                            input logic [6:0] ca, input logic d);
      check({tag, ".anodes"},   32'(bus.anodes),   32'(an));
      check({tag, ".cathodes"}, 32'(bus.cathodes), 32'(ca));
      check({tag, ".dp"},       32'(bus.dp),       32'(d));
   endtask

   task automatic wait_fd(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (bus.frame_done !== 1'b1 && n < 40);
      check({tag, ".frame_done"}, 32'(bus.frame_done), 32'd1);
   endtask

   task automatic drive(input logic [15:0] d, input logic [3:0] en,
                        input logic [3:0] p, input logic blz);
      bus.digits_in = d;
      bus.digit_en  = en;
      bus.dp_in     = p;
      bus.blank_lz  = blz;
   endtask

   task automatic load_bank(input logic [15:0] d, input logic [3:0] en,
                            input logic [3:0] p, input logic blz);
      drive(d, en, p, blz);
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.load = 1'b0;
      drive(16'h0, 4'h0, 4'h0, 1'b0);
      step(3);
      reset = 1'b0;
      check_out("reset", 4'hF, 7'h7F, 1'b1);
      check("reset.frame_done", 32'(bus.frame_done), 32'd0);
      step(6);
      check_out("idle", 4'hF, 7'h7F, 1'b1);

      // Full four-digit rotation of 12AF, dp on digit 2.
      load_bank(16'h12AF, 4'hF, 4'b0100, 1'b0);
      wait_fd("rot");
      check_out("rot.d0", 4'hE, 7'h0E, 1'b1);
      step(3);
      check("rot.d0_hold", 32'(bus.anodes), 32'hE);
      step(1);
      check_out("rot.d1", 4'hD, 7'h08, 1'b1);
      check("rot.fd_low", 32'(bus.frame_done), 32'd0);
      step(4);
      check_out("rot.d2", 4'hB, 7'h24, 1'b0);
      step(4);
      check_out("rot.d3", 4'h7, 7'h79, 1'b1);
      step(4);
      check("rot.wrap_fd", 32'(bus.frame_done), 32'd1);
      check("rot.wrap_an", 32'(bus.anodes), 32'hE);

      // Sparse enable: digits 0 and 2 only.
      load_bank(16'h12AF, 4'b0101, 4'b0100, 1'b0);
      wait_fd("sparse");
      check_out("sparse.d0", 4'hE, 7'h0E, 1'b1);
      step(4);
      check_out("sparse.d2", 4'hB, 7'h24, 1'b0);
      check("sparse.fd_low", 32'(bus.frame_done), 32'd0);
      step(4);
      check("sparse.fd", 32'(bus.frame_done), 32'd1);
      check("sparse.wrap_an", 32'(bus.anodes), 32'hE);

      // Leading-zero blanking of 0070.
      load_bank(16'h0070, 4'hF, 4'h0, 1'b1);
      wait_fd("lz");
      check_out("lz.d0", 4'hE, 7'h40, 1'b1);
      step(4);
      check_out("lz.d1", 4'hD, 7'h78, 1'b1);
      step(4);
      check_out("lz.d2", 4'hB, 7'h7F, 1'b1);
      step(4);
      check_out("lz.d3", 4'h7, 7'h7F, 1'b1);
      step(4);
      check("lz.fd", 32'(bus.frame_done), 32'd1);

      // Two loads mid-frame: current frame untouched, last load wins next frame.
      step(1);
      drive(16'h1111, 4'hF, 4'h0, 1'b0);
      bus.load = 1'b1;
      step(1);
      drive(16'h2222, 4'hF, 4'h0, 1'b0);
      step(1);
      bus.load = 1'b0;
      step(1);
      check_out("mid.d1", 4'hD, 7'h78, 1'b1);
      step(4);
      check_out("mid.d2", 4'hB, 7'h7F, 1'b1);
      wait_fd("mid");
      check_out("mid.next", 4'hE, 7'h24, 1'b1);

      // Load exactly on the boundary cycle bypasses into the new frame.
      step(15);
      drive(16'h3333, 4'hF, 4'h0, 1'b0);
      bus.load = 1'b1;
      step(1);
      bus.load = 1'b0;
      check("byp.fd", 32'(bus.frame_done), 32'd1);
      check_out("byp.d0", 4'hE, 7'h30, 1'b1);

      // No digits enabled: dark display, frame_done on every tick.
      load_bank(16'h3333, 4'h0, 4'h0, 1'b0);
      wait_fd("off");
      check_out("off", 4'hF, 7'h7F, 1'b1);
      step(4);
      check("off.fd_tick1", 32'(bus.frame_done), 32'd1);
      step(1);
      check("off.fd_low", 32'(bus.frame_done), 32'd0);
      step(3);
      check("off.fd_tick2", 32'(bus.frame_done), 32'd1);

      // Reset landing on a boundary cycle: no frame_done, outputs dark.
      load_bank(16'h12AF, 4'hF, 4'b0100, 1'b0);
      wait_fd("pre_rst");
      check("pre_rst.an", 32'(bus.anodes), 32'hE);
      step(15);
      reset = 1'b1;
      step(1);
      check_out("rst_mid", 4'hF, 7'h7F, 1'b1);
      check("rst_mid.frame_done", 32'(bus.frame_done), 32'd0);
      reset = 1'b0;
      step(8);
      check("rst_after.an", 32'(bus.anodes), 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
